// File: rtl/zeroskip_enc_fifo_mac64.sv
`default_nettype none
// ============================================================================
// Module      : zeroskip_enc_fifo_mac64
// Description : Elastic tile buffer between the MAC64 zero-skip encoder and
//               the MAC64 array. It uses a first-word fall-through circular
//               buffer. Tiles arriving while full are dropped and flagged.
//               The encoder is throttled by a registered enable that keeps
//               AFULL_MARGIN slots in reserve.
//               Optional statistics outputs are enabled by the macro
//               ZS_FIFO_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module zeroskip_enc_fifo_mac64 #(
    parameter int M            = 8,
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 8,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                                  clk,
    input  logic                                  a_rst,
    input  logic [M-1:0][M-1:0][DATA_W-1:0]       enc_din,
    input  logic                                  enc_vld_i,
    output logic                                  up_enable_o,
    output logic [M-1:0][M-1:0][DATA_W-1:0]       mac_dout,
    output logic                                  mac_vld_o,
    input  logic                                  mac_rdy_i,
    input  logic                                  flush_i,
    input  logic                                  ovf_clr_i,
`ifdef ZS_FIFO_STATS_EN
    output logic [$clog2(DEPTH):0]                occ_o,
    output logic [$clog2(DEPTH):0]                hwm_o,
    output logic [15:0]                           drop_cnt_o,
`endif
    output logic                                  overflow_o
);

    localparam int            AW       = $clog2(DEPTH);
    localparam int            CW       = AW + 1;
    localparam logic [CW-1:0] C_DEPTH  = CW'(DEPTH);
    localparam logic [CW-1:0] C_MARGIN = CW'(AFULL_MARGIN);

    logic [M-1:0][M-1:0][DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          up_enable_q, up_enable_d;
    logic          overflow_q, overflow_d;
    logic          w_pop, w_push, w_drop;
    logic [CW-1:0] w_free;

    // Handshake decode; flush overrides both directions and is not a drop
    always_comb begin
        w_pop  = (count_q != '0) & mac_rdy_i & ~flush_i;
        w_push = enc_vld_i & ~flush_i & ((count_q < C_DEPTH) | w_pop);
        w_drop = enc_vld_i & ~flush_i & ~w_push;
    end

    // Next-state for pointers, occupancy, encoder enable and overflow flag
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        w_free      = '0;
        up_enable_d = 1'b1;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
            count_d     = count_q + CW'(w_push) - CW'(w_pop);
            w_free      = C_DEPTH - count_d;
            up_enable_d = (w_free > C_MARGIN);
        end
        // A drop in the same cycle as a clear keeps the flag set
        if (w_drop)         overflow_d = 1'b1;
        else if (ovf_clr_i) overflow_d = 1'b0;
        else                overflow_d = overflow_q;
    end

    // Control state registers
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            up_enable_q <= 1'b1;
            overflow_q  <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            up_enable_q <= up_enable_d;
            overflow_q  <= overflow_d;
        end
    end

    // Tile storage; cleared on reset so the head reads zero afterwards
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_push) begin
            mem_q[wr_ptr_q] <= enc_din;
        end
    end

    assign mac_dout    = mem_q[rd_ptr_q];
    assign mac_vld_o   = (count_q != '0);
    assign up_enable_o = up_enable_q;
    assign overflow_o  = overflow_q;

`ifdef ZS_FIFO_STATS_EN
    logic [CW-1:0] hwm_q, hwm_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;

    // Statistics next-state; a clear restarts tracking from the new occupancy
    always_comb begin
        if (ovf_clr_i) begin
            hwm_d      = count_d;
            drop_cnt_d = {15'd0, w_drop};
        end else begin
            hwm_d      = (count_d > hwm_q) ? count_d : hwm_q;
            drop_cnt_d = (w_drop && (drop_cnt_q != 16'hFFFF)) ?
                         drop_cnt_q + 16'd1 : drop_cnt_q;
        end
    end

    // Statistics registers; flush leaves them untouched
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            hwm_q      <= '0;
            drop_cnt_q <= '0;
        end else begin
            hwm_q      <= hwm_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign occ_o      = count_q;
    assign hwm_o      = hwm_q;
    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_zeroskip_enc_fifo_mac64.sv
`default_nettype none
// ============================================================================
// Module      : tb_zeroskip_enc_fifo_mac64
// Description : Directed self-checking bench for zeroskip_enc_fifo_mac64
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zeroskip_enc_fifo_mac64;

    logic                      clk;
    logic                      a_rst;
    logic [7:0][7:0][7:0]      enc_din;
    logic                      enc_vld_i;
    logic                      up_enable_o;
    logic [7:0][7:0][7:0]      mac_dout;
    logic                      mac_vld_o;
    logic                      mac_rdy_i;
    logic                      flush_i;
    logic                      ovf_clr_i;
    logic                      overflow_o;
`ifdef ZS_FIFO_STATS_EN
    logic [3:0]                occ_o;
    logic [3:0]                hwm_o;
    logic [15:0]               drop_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    zeroskip_enc_fifo_mac64 dut (
        .clk         (clk),
        .a_rst       (a_rst),
        .enc_din     (enc_din),
        .enc_vld_i   (enc_vld_i),
        .up_enable_o (up_enable_o),
        .mac_dout    (mac_dout),
        .mac_vld_o   (mac_vld_o),
        .mac_rdy_i   (mac_rdy_i),
        .flush_i     (flush_i),
        .ovf_clr_i   (ovf_clr_i),
`ifdef ZS_FIFO_STATS_EN
        .occ_o       (occ_o),
        .hwm_o       (hwm_o),
        .drop_cnt_o  (drop_cnt_o),
`endif
        .overflow_o  (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] tile(input int k);
        logic [31:0] w;
        w = 32'hC3A5_0000 ^ 32'(k * 32'h0101_0001);
        return {16{w}};
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst     = 1'b1;
        enc_din   = '0;
        enc_vld_i = 1'b0;
        mac_rdy_i = 1'b0;
        flush_i   = 1'b0;
        ovf_clr_i = 1'b0;
        tick();
        tick();
        chk("rst_vld",  512'(mac_vld_o),   512'd0);
        chk("rst_dout", mac_dout,          512'd0);
        chk("rst_upen", 512'(up_enable_o), 512'd1);
        chk("rst_ovf",  512'(overflow_o),  512'd0);
        a_rst = 1'b0;
        tick();

        // Single tile pass-through
        enc_din = tile(0); enc_vld_i = 1'b1; mac_rdy_i = 1'b1;
        tick();
        enc_vld_i = 1'b0;
        chk("one_vld",  512'(mac_vld_o),   512'd1);
        chk("one_dout", mac_dout,          tile(0));
        chk("one_upen", 512'(up_enable_o), 512'd1);
        tick();
        chk("one_empty", 512'(mac_vld_o),   512'd0);
        chk("one_upen2", 512'(up_enable_o), 512'd1);

        // Fill with no consumer; enable drops after the 6th push
        mac_rdy_i = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            enc_din = tile(n); enc_vld_i = 1'b1;
            tick();
            chk("fill_upen", 512'(up_enable_o), 512'(n <= 5));
            chk("fill_head", mac_dout,          tile(1));
        end
        chk("fill_ovf", 512'(overflow_o), 512'd0);

        // Ninth tile dropped
        enc_din = tile(9);
        tick();
        enc_vld_i = 1'b0;
        chk("drop_ovf",  512'(overflow_o),  512'd1);
        chk("drop_upen", 512'(up_enable_o), 512'd0);
`ifdef ZS_FIFO_STATS_EN
        chk("drop_cnt", 512'(drop_cnt_o), 512'd1);
`endif
        mac_rdy_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_vld",  512'(mac_vld_o), 512'd1);
            chk("drain_dout", mac_dout,        tile(1 + i));
            tick();
        end
        chk("drain_empty", 512'(mac_vld_o), 512'd0);
        mac_rdy_i = 1'b0;

        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        chk("clr_ovf", 512'(overflow_o), 512'd0);

        // Full buffer with simultaneous push and pop
        for (int n = 10; n <= 17; n++) begin
            enc_din = tile(n); enc_vld_i = 1'b1;
            tick();
        end
        enc_din = tile(18); mac_rdy_i = 1'b1;
        tick();
        enc_vld_i = 1'b0;
        chk("pp_ovf",  512'(overflow_o),  512'd0);
        chk("pp_upen", 512'(up_enable_o), 512'd0);
        for (int i = 0; i < 8; i++) begin
            chk("pp_vld",  512'(mac_vld_o), 512'd1);
            chk("pp_dout", mac_dout,        (i < 7) ? tile(11 + i) : tile(18));
            tick();
        end
        chk("pp_empty", 512'(mac_vld_o), 512'd0);
        mac_rdy_i = 1'b0;

        // Flush at count 5 with a tile presented
        for (int n = 19; n <= 23; n++) begin
            enc_din = tile(n); enc_vld_i = 1'b1;
            tick();
        end
        enc_din = tile(24); flush_i = 1'b1;
        tick();
        flush_i = 1'b0; enc_vld_i = 1'b0;
        chk("fl_vld",  512'(mac_vld_o),   512'd0);
        chk("fl_upen", 512'(up_enable_o), 512'd1);
        chk("fl_ovf",  512'(overflow_o),  512'd0);
`ifdef ZS_FIFO_STATS_EN
        chk("fl_occ", 512'(occ_o), 512'd0);
        chk("fl_hwm", 512'(hwm_o), 512'd8);
`endif
        enc_din = tile(25); enc_vld_i = 1'b1;
        tick();
        chk("fl_next", mac_dout, tile(25));

        // Refill to full, drop, then clear together with another drop
        for (int n = 26; n <= 32; n++) begin
            enc_din = tile(n);
            tick();
        end
        chk("f2_ovf0", 512'(overflow_o), 512'd0);
        enc_din = tile(33);
        tick();
        chk("f2_ovf1", 512'(overflow_o), 512'd1);
        enc_din = tile(34); ovf_clr_i = 1'b1;
        tick();
        chk("f2_setwins", 512'(overflow_o), 512'd1);
        enc_vld_i = 1'b0;
        tick();
        ovf_clr_i = 1'b0;
        chk("f2_clr", 512'(overflow_o), 512'd0);
`ifdef ZS_FIFO_STATS_EN
        chk("f2_dcnt", 512'(drop_cnt_o), 512'd0);
`endif
        chk("f2_head", mac_dout, tile(25));

        // Asynchronous reset mid-operation
        #2;
        a_rst = 1'b1;
        #1;
        chk("ar_vld",  512'(mac_vld_o),   512'd0);
        chk("ar_dout", mac_dout,          512'd0);
        chk("ar_upen", 512'(up_enable_o), 512'd1);
        chk("ar_ovf",  512'(overflow_o),  512'd0);
        tick();
        a_rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
